// File: rtl/xunit_f_if.sv
// Start/config/stream bundle for the xunit_f SHA-256 compression core.
interface xunit_f_if;
  logic        run;
  logic        done;
  logic        init;
  logic [7:0]  delay0;
  logic [31:0] in0;
  logic [31:0] out0;

  // run is a one-cycle start strobe. It is honoured only while done is high
  // and ignored otherwise. The W stream and the digest stream are
  // position-timed relative to the accepted run edge; there is no per-word
  // valid or ready.
  modport master (output run, init, delay0, in0, input done, out0);
  modport slave  (input run, init, delay0, in0, output done, out0);
endinterface

// File: rtl/xunit_f.sv
// SHA-256 compression core: takes 64 schedule words W[t] after an optional
// start delay, folds them into the chaining value H, then streams out 8 digest words.
module xunit_f #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  xunit_f_if.slave   bus,
  output logic [2:0] dbg_state
);

  if (DATA_W != 32 || DELAY_W < 8) begin : g_param_check
    $error("xunit_f supports DATA_W == 32 only");
  end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ROUND, S_ADD, S_EMIT} state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic [5:0]  rnd;
  logic [2:0]  idx;
  logic [31:0] hv [8];   // chaining value H0..H7
  logic [31:0] wv [8];   // working variables a..h
  logic [31:0] out_r;
  logic [31:0] sig0, sig1, ch, maj, t1, t2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.run) state_nx = (bus.delay0 == 8'd0) ? S_ROUND : S_WAIT;
      S_WAIT:  if (cnt == 8'd1) state_nx = S_ROUND;
      S_ROUND: if (rnd == 6'd63) state_nx = S_ADD;
      S_ADD:   state_nx = S_EMIT;
      S_EMIT:  if (idx == 3'd7) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.done  = (state == S_IDLE);
    bus.out0  = out_r;
    dbg_state = state;
  end

  always_comb begin
    sig1 = rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25);
    ch   = (wv[4] & wv[5]) ^ (~wv[4] & wv[6]);
    t1   = wv[7] + sig1 + ch + K[rnd] + bus.in0;
    sig0 = rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22);
    maj  = (wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]);
    t2   = sig0 + maj;
  end

  // Reset restores H to the IV so an aborted block never leaves a partial chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 8'd0;
      rnd   <= 6'd0;
      idx   <= 3'd0;
      out_r <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        wv[i] <= 32'd0;
        hv[i] <= IV[i];
      end
    end else begin
      case (state)
        S_IDLE: if (bus.run) begin
          cnt <= bus.delay0;
          rnd <= 6'd0;
          for (int i = 0; i < 8; i++) begin
            wv[i] <= bus.init ? IV[i] : hv[i];
            if (bus.init) hv[i] <= IV[i];
          end
        end
        S_WAIT: cnt <= cnt - 8'd1;
        S_ROUND: begin
          wv[7] <= wv[6];
          wv[6] <= wv[5];
          wv[5] <= wv[4];
          wv[4] <= wv[3] + t1;
          wv[3] <= wv[2];
          wv[2] <= wv[1];
          wv[1] <= wv[0];
          wv[0] <= t1 + t2;
          rnd   <= rnd + 6'd1;
        end
        S_ADD: begin
          for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
          idx <= 3'd0;
        end
        S_EMIT: begin
          out_r <= hv[idx];
          idx   <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xunit_f.sv
// Self-checking bench for xunit_f: known SHA-256 vectors, start delays,
// ignored run pulses and a mid-block reset abort.
module tb_xunit_f;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  xunit_f_if bus ();

  xunit_f dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] msg   [16];
  logic [31:0] w_arr [64];

  localparam logic [31:0] DIG_ABC [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [31:0] DIG_TWO [8] = '{
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic expand();
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w_arr[t] = msg[t];
      else begin
        s0 = rr(w_arr[t-15], 7) ^ rr(w_arr[t-15], 18) ^ (w_arr[t-15] >> 3);
        s1 = rr(w_arr[t-2], 17) ^ rr(w_arr[t-2], 19) ^ (w_arr[t-2] >> 10);
        w_arr[t] = w_arr[t-16] + s0 + w_arr[t-7] + s1;
      end
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    expand();
  endtask

  task automatic push_digest(input int sel);
    for (int i = 0; i < 8; i++) exp_q.push_back(sel == 0 ? DIG_ABC[i] : DIG_TWO[i]);
  endtask

  // One block: run strobe, optional WAIT, 64 W words, ADD, 8 emitted words.
  // pulse_rnd >= 0 re-pulses run during that round; abort_rnd >= 0 resets there.
  task automatic run_block(input logic ini, input logic [7:0] dly, input bit chk,
                           input int pulse_rnd, input int abort_rnd);
    logic [31:0] exp_w, last_w;
    last_w = 32'd0;
    @(negedge clk);
    bus.run = 1'b1; bus.init = ini; bus.delay0 = dly; bus.in0 = $urandom;
    @(posedge clk); #1;
    bus.run = 1'b0; bus.init = 1'($urandom_range(0, 1));
    check("done_busy", {31'd0, bus.done}, 32'd0);
    for (int e = 0; e < int'(dly); e++) begin
      bus.in0 = $urandom;
      @(posedge clk); #1;
    end
    for (int r = 0; r < 64; r++) begin
      bus.in0 = w_arr[r];
      if (r == abort_rnd) begin
        rst = 1'b0;
        #1;
        check("abort_done", {31'd0, bus.done}, 32'd1);
        check("abort_out0", bus.out0, 32'd0);
        check("abort_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (r == pulse_rnd) bus.run = 1'b1;
      @(posedge clk); #1;
      bus.run = 1'b0;
    end
    bus.in0 = $urandom;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (chk) begin
        exp_w = exp_q.pop_front();
        check($sformatf("out0[%0d]", i), bus.out0, exp_w);
        last_w = exp_w;
      end
      check($sformatf("done@%0d", i), {31'd0, bus.done}, (i == 7) ? 32'd1 : 32'd0);
    end
    if (chk) begin
      repeat (3) @(posedge clk);
      #1;
      check("out0_hold", bus.out0, last_w);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0; bus.init = 1'b0; bus.delay0 = 8'd0; bus.in0 = 32'd0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, bus.done}, 32'd1);
    check("rst_out0", bus.out0, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      bus.in0 = $urandom;
      @(posedge clk); #1;
      if (c % 25 == 0) begin
        check("idle_done", {31'd0, bus.done}, 32'd1);
        check("idle_out0", bus.out0, 32'd0);
      end
    end

    // "abc", no start delay
    load_abc();
    push_digest(0);
    run_block(1'b1, 8'd0, 1'b1, -1, -1);

    // two-block message: block 1 with new IV, padding block chained
    for (int i = 0; i < 14; i++)
      msg[i] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
    msg[14] = 32'h80000000;
    msg[15] = 32'h00000000;
    expand();
    run_block(1'b1, 8'd0, 1'b0, -1, -1);
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[15] = 32'h000001c0;
    expand();
    push_digest(1);
    run_block(1'b0, 8'd0, 1'b1, -1, -1);

    // start delays: 16 and a random one
    load_abc();
    push_digest(0);
    run_block(1'b1, 8'd16, 1'b1, -1, -1);
    push_digest(0);
    run_block(1'b1, 8'($urandom_range(1, 40)), 1'b1, -1, -1);

    // run re-pulsed mid-rounds must be ignored
    push_digest(0);
    run_block(1'b1, 8'd0, 1'b1, 10, -1);

    // chain from the abc digest, abort at round 30; H must return to IV
    run_block(1'b0, 8'd0, 1'b0, -1, 30);
    push_digest(0);
    run_block(1'b0, 8'd0, 1'b1, -1, -1);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
